// File: rtl/apb_mem_slave.sv
// apb_mem_slave: parametrised APB3/APB4 scratch memory with per-direction wait
// states, byte-lane writes, a write-protected window and PSLVERR on
// out-of-range / protected / non-secure accesses.
//
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE    APB control
//   PADDR[31:0]              byte address (low lane bits ignored)
//   PWDATA, PSTRB            write data and byte-lane strobes
//   PPROT[2:0]               protection attributes (bit 1 = non-secure)
//   PRDATA, PREADY, PSLVERR  registered completion outputs
//
// state | meaning
// IDLE  | waiting for a setup phase
// WAIT  | counting down wait states, aborts if PSEL drops
// ACK   | one-cycle completion, PREADY high
module apb_mem_slave #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SIZE_IN_BYTES = 4096,
  parameter int unsigned RD_DELAY      = 0,
  parameter int unsigned WR_DELAY      = 0,
  parameter int unsigned RO_BASE       = 0,
  parameter int unsigned RO_SIZE       = 0,
  parameter int unsigned SECURE_ONLY   = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic [31:0]             PADDR,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned BW    = $clog2(NB);
  localparam int unsigned AW    = $clog2(SIZE_IN_BYTES);
  localparam int unsigned WORDS = SIZE_IN_BYTES / NB;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam bit          RO_EN = (RO_SIZE != 0);
  localparam logic [31:0] RO_LAST = (RO_SIZE == 0) ? 32'd0 : 32'(RO_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic          setup;
  logic [IW-1:0] setup_idx;
  logic [31:0]   word_base;
  logic [31:0]   ro_offs;
  logic          setup_err;
  logic [7:0]    setup_delay;
  logic          go_ack;
  logic          mem_we;
  logic          unused_prot;

  assign unused_prot = ^{PPROT[2], PPROT[0]};

  assign setup       = PSEL & ~PENABLE;
  assign setup_idx   = IW'(PADDR[AW-1:0] >> BW);
  assign word_base   = PADDR & ~32'(NB - 1);
  // Unsigned offset wraps for addresses below the window, so one compare covers both bounds.
  assign ro_offs     = word_base - 32'(RO_BASE);
  assign setup_err   = (PADDR >= 32'(SIZE_IN_BYTES))
                     | (PWRITE & RO_EN & (ro_offs <= RO_LAST))
                     | ((SECURE_ONLY != 0) & PPROT[1]);
  assign setup_delay = PWRITE ? 8'(WR_DELAY) : 8'(RD_DELAY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    go_ack    = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          idx_d = setup_idx;
          wr_d  = PWRITE;
          err_d = setup_err;
          // Errors bypass the wait states entirely.
          if (setup_err || setup_delay == 8'd0) begin
            go_ack = 1'b1;
          end else begin
            cnt_d   = setup_delay;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == 8'd1) begin
          cnt_d  = 8'd0;
          go_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_ack) begin
      state_d   = ACK;
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!wr_d) prdata_d = err_d ? '0 : mem[idx_d];
    end
  end

  assign mem_we = go_ack & wr_d & ~err_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (PSTRB[i]) mem[idx_d][i*8 +: 8] <= PWDATA[i*8 +: 8];
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed checks of apb_mem_slave across five builds
// sharing one APB bus, each with its own PSEL.
//   0: 32-bit, no delays          1: 32-bit, RD 3 / WR 1
//   2: 32-bit, delays 5, RO window 0x100..0x1FF, secure only
//   3: 32-bit, delays 4           4: 64-bit, no delays
module tb_apb_mem_slave;

  logic        PCLK;
  logic        PRESETn;
  logic [4:0]  psel;
  logic [31:0] paddr;
  logic        penable;
  logic        pwrite;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prd32 [4];
  logic [63:0] prd64;
  logic [4:0]  pready;
  logic [4:0]  pslverr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_ready = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_mem_slave #(.DATA_WIDTH(32)) u_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PPROT(pprot),
    .PRDATA(prd32[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave #(.DATA_WIDTH(32), .RD_DELAY(3), .WR_DELAY(1)) u_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PPROT(pprot),
    .PRDATA(prd32[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave #(.DATA_WIDTH(32), .RD_DELAY(5), .WR_DELAY(5), .RO_BASE(32'h100),
                  .RO_SIZE(32'h100), .SECURE_ONLY(1)) u_c (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PPROT(pprot),
    .PRDATA(prd32[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  apb_mem_slave #(.DATA_WIDTH(32), .RD_DELAY(4), .WR_DELAY(4)) u_e (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[3]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PPROT(pprot),
    .PRDATA(prd32[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

  apb_mem_slave #(.DATA_WIDTH(64)) u_d (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[4]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prd64), .PREADY(pready[4]), .PSLVERR(pslverr[4]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 after the completing edge so a
  // following call drives its setup phase with no idle cycle in between.
  // cy = access cycle (1-based) in which PREADY was seen high.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [63:0] wd, input logic [7:0] st, input logic [2:0] pr,
                      output logic [63:0] rd, output logic err, output int cy);
    bit got;
    got = 1'b0;
    rd  = '0;
    err = 1'b0;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
    @(posedge PCLK); #1;
    penable = 1'b1;
    cy = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (pready[d]) begin
        got = 1'b1;
        t_ready = cyc;
        err = pslverr[d];
        rd = (d == 4) ? prd64 : {32'h0, prd32[d[1:0]]};
        break;
      end
      @(posedge PCLK); #1;
      cy++;
    end
    if (!got) check("xfer_timeout", 64'd0, 64'd1);
    @(posedge PCLK); #1;
    psel = '0; penable = 1'b0;
  endtask

  logic [63:0] rd, orig;
  logic        er;
  int          cy, s;

  initial begin
    PRESETn = 1'b0;
    psel = '0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready",  64'(pready),    64'd0);
    check("rst_pslverr", 64'(pslverr),   64'd0);
    check("rst_prdata",  64'(prd32[0]),  64'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // zero wait states
    xfer(0, 1, 32'h10, 64'hDEADBEEF, 8'hF, 3'b000, rd, er, cy);
    check("a_wr_cyc", 64'(cy), 64'd1);
    check("a_wr_err", 64'(er), 64'd0);
    xfer(0, 0, 32'h10, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("a_rd_cyc",  64'(cy), 64'd1);
    check("a_rd_err",  64'(er), 64'd0);
    check("a_rd_data", rd, 64'hDEADBEEF);

    // byte lanes
    xfer(0, 1, 32'h40, 64'hFFFFFFFF, 8'hF, 3'b000, rd, er, cy);
    xfer(0, 1, 32'h40, 64'h00AA00BB, 8'h5, 3'b000, rd, er, cy);
    xfer(0, 0, 32'h40, 64'h0, 8'h0, 3'b000, rd, er, cy);
    check("strb_data", rd, 64'hFFAAFFBB);
    xfer(0, 1, 32'h40, 64'h12345678, 8'h0, 3'b000, rd, er, cy);
    check("strb0_err",    64'(er), 64'd0);
    check("prdata_hold",  64'(prd32[0]), 64'hFFAAFFBB);
    xfer(0, 0, 32'h42, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("strb0_data", rd, 64'hFFAAFFBB);

    // wait states
    xfer(1, 1, 32'h20, 64'h12345678, 8'hF, 3'b000, rd, er, cy);
    check("b_wr_cyc", 64'(cy), 64'd2);
    xfer(1, 0, 32'h20, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("b_rd_cyc",  64'(cy), 64'd4);
    check("b_rd_data", rd, 64'h12345678);

    // errors, delays 5
    xfer(2, 1, 32'h40, 64'h55, 8'hF, 3'b000, rd, er, cy);
    check("c_wr_cyc", 64'(cy), 64'd6);
    xfer(2, 0, 32'h40, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("c_rd_data", rd, 64'h55);
    check("c_rd_cyc",  64'(cy), 64'd6);
    xfer(2, 0, 32'h1000, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("oor_err",  64'(er), 64'd1);
    check("oor_data", rd, 64'd0);
    check("oor_cyc",  64'(cy), 64'd1);
    xfer(2, 0, 32'hFFC, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("top_word_err", 64'(er), 64'd0);
    xfer(2, 0, 32'h180, 64'h0, 8'hF, 3'b000, orig, er, cy);
    xfer(2, 1, 32'h180, 64'hA5A5A5A5, 8'hF, 3'b000, rd, er, cy);
    check("ro_wr_err", 64'(er), 64'd1);
    check("ro_wr_cyc", 64'(cy), 64'd1);
    xfer(2, 0, 32'h180, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("ro_rd_err",  64'(er), 64'd0);
    check("ro_rd_data", rd, orig);
    xfer(2, 1, 32'h1FC, 64'hA5A5A5A5, 8'hF, 3'b000, rd, er, cy);
    check("ro_last_err", 64'(er), 64'd1);
    xfer(2, 1, 32'h200, 64'hA5A5A5A5, 8'hF, 3'b000, rd, er, cy);
    check("ro_after_err", 64'(er), 64'd0);
    xfer(2, 1, 32'hFC, 64'h3C3C3C3C, 8'hF, 3'b000, rd, er, cy);
    check("ro_before_err", 64'(er), 64'd0);
    xfer(2, 0, 32'h40, 64'h0, 8'hF, 3'b010, rd, er, cy);
    check("nsec_err",  64'(er), 64'd1);
    check("nsec_cyc",  64'(cy), 64'd1);
    check("nsec_data", rd, 64'd0);

    // 64-bit, back-to-back
    s = cyc;
    xfer(4, 1, 32'h8, 64'h0123456789ABCDEF, 8'hFF, 3'b000, rd, er, cy);
    xfer(4, 0, 32'h8, 64'h0, 8'hFF, 3'b000, rd, er, cy);
    check("d_b2b_span", 64'(t_ready - s), 64'd3);
    check("d_rd8",      rd, 64'h0123456789ABCDEF);
    xfer(4, 0, 32'hC, 64'h0, 8'hFF, 3'b000, rd, er, cy);
    check("d_rdC",      rd, 64'h0123456789ABCDEF);

    // abort while waiting
    xfer(3, 1, 32'h30, 64'h11111111, 8'hF, 3'b000, rd, er, cy);
    check("e_wr_cyc", 64'(cy), 64'd5);
    psel = 5'b01000; penable = 1'b0; paddr = 32'h30; pwrite = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin psel = '0; penable = 1'b0; end
      @(negedge PCLK);
      check("abort_no_ready", 64'(pready[3]), 64'd0);
      @(posedge PCLK); #1;
    end
    xfer(3, 0, 32'h30, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("abort_then_cyc",  64'(cy), 64'd5);
    check("abort_then_data", rd, 64'h11111111);

    // reset mid-wait of a write
    psel = 5'b01000; penable = 1'b0; paddr = 32'h30; pwrite = 1'b1;
    pwdata = 64'h22222222; pstrb = 8'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_prdata",  64'(prd32[3]),  64'd0);
    check("rst_mid_pready",  64'(pready[3]), 64'd0);
    check("rst_mid_pslverr", 64'(pslverr[3]), 64'd0);
    psel = '0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(3, 0, 32'h30, 64'h0, 8'hF, 3'b000, rd, er, cy);
    check("rst_mid_nowrite", rd, 64'h11111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB3/APB4 memory slave, the next generation of the team's single-width APB memory model. Adds configurable data width, separate read/write wait states, PSTRB byte-lane writes, a write-protected window and address/security error responses on PSLVERR. Sits behind the APB bridge as a scratch RAM and as the reference target for BFM regression.

Parameters:
DATA_WIDTH, 32, bus width in bits; 32 or 64 only.
SIZE_IN_BYTES, 4096, memory size; power of two, at least DATA_WIDTH/8.
RD_DELAY, 0, wait states inserted on reads (0..255).
WR_DELAY, 0, wait states inserted on writes (0..255).
RO_BASE, 0, byte offset of the write-protected window; aligned to DATA_WIDTH/8.
RO_SIZE, 0, size of the write-protected window in bytes; 0 disables it.
SECURE_ONLY, 0, if 1, non-secure accesses (PPROT[1]=1) return an error.

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select
PADDR  in  32  byte address
PENABLE  in  1  access phase
PWRITE  in  1  1=write, 0=read
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  byte-lane write strobes
PPROT  in  3  protection attributes
PRDATA  out  DATA_WIDTH  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset is PRESETn, asynchronous, active-low; the clock is PCLK. On reset: PRDATA=0, PREADY=0, PSLVERR=0, state=IDLE, counter=0. Memory contents are not reset.
- Word index = PADDR[log2(SIZE_IN_BYTES)-1 : log2(DATA_WIDTH/8)]. Low address bits are ignored, so there are no misalignment errors.
- Error conditions are evaluated at the setup edge:
  - PADDR >= SIZE_IN_BYTES.
  - A write whose word lies in [RO_BASE, RO_BASE+RO_SIZE).
  - SECURE_ONLY=1 and PPROT[1]=1.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on a sampled edge with PSEL=1 and PENABLE=0, latch the address, direction and error flag.
  - Error, or selected delay=0: go to ACK.
  - Otherwise: load counter = delay and go to WAIT.
- WAIT: decrement the counter each cycle. When counter==1, go to ACK.
- Entering ACK: PREADY<=1 and PSLVERR<=error. At this same edge:
  - Non-error write: update each lane i where PSTRB[i]=1.
  - Non-error read: PRDATA <= mem[word].
  - Error read: PRDATA <= 0.
  - Error write: memory unchanged.
- ACK lasts exactly one cycle, then return to IDLE with PREADY<=0 and PSLVERR<=0.
- Latency: with delay N, PREADY is high in access cycle N+1. N=0 gives the zero-wait APB transfer: setup and access only.
- Error transfers always complete with zero wait states, regardless of RD_DELAY/WR_DELAY.
- PRDATA holds its last value outside read completions; writes do not change it.
- Back-to-back: the setup phase of the next transfer may immediately follow ACK. IDLE must accept it with no bubble.
- Reads ignore PSTRB. A write with PSTRB=0 completes OKAY with no memory change.
- PSEL deasserted while in WAIT: abort, return to IDLE, no memory update, PREADY stays 0.
- PWDATA, PSTRB and PWRITE are sampled at the ACK-entry edge. They must be stable per the APB rules.
- Reset asserted mid-transfer: outputs go to reset values immediately. Any write not yet at the ACK edge is discarded.
- An APB3 build ties PSTRB to all ones and PPROT to 0 at the instance level; the block itself has no mode switch.

Test Plan:
- DATA_WIDTH=32, zero delays: write 0xDEADBEEF to 0x10, then read 0x10. Both complete in 2 cycles with PREADY high in the access cycle; PRDATA=0xDEADBEEF, PSLVERR=0.
- RD_DELAY=3, WR_DELAY=1: write 0x12345678 to 0x20, then read it back. PREADY is high in access cycle 2 for the write and cycle 4 for the read; the read returns 0x12345678.
- Strobes: write 0xFFFFFFFF to 0x40, then write 0x00AA00BB with PSTRB=4'b0101. Reading 0x40 returns 0xFFAAFFBB; a further write with PSTRB=0 leaves it unchanged.
- Errors with SIZE_IN_BYTES=4096, RO_BASE=0x100, RO_SIZE=0x100, SECURE_ONLY=1:
  - Read 0x1000 gives PSLVERR=1 and PRDATA=0.
  - Write to 0x180 gives PSLVERR=1, and a later read of 0x180 shows the original data.
  - Read with PPROT=3'b010 gives PSLVERR=1.
  - All three complete with zero wait states even when delays are 5.
- DATA_WIDTH=64: write 0x0123456789ABCDEF to 0x8, then read 0x8 and 0xC. Both return the same 64-bit word; back-to-back transfers show no idle cycle between ACK and the next setup.
- RD_DELAY=4: drop PSEL during WAIT and check no PREADY pulse and the FSM back in IDLE. Assert PRESETn low mid-WAIT of a write and check the outputs are 0 and the write is not performed.
